// File: rtl/fu_rr_scheduler_pkg.sv
// Shared FU definitions: port widths, operand-select codes, one-hot opcodes
// and the scheduler FSM state type.
package fu_pkg;

    localparam int FU_INSTR_W = 8;
    localparam int FU_SEL_W   = 3;

    localparam logic [FU_SEL_W-1:0] SEL_BC = 3'b011;
    localparam logic [FU_SEL_W-1:0] SEL_AC = 3'b101;
    localparam logic [FU_SEL_W-1:0] SEL_AB = 3'b110;

    localparam logic [FU_INSTR_W-1:0] OP_ADD = 8'h01;
    localparam logic [FU_INSTR_W-1:0] OP_SUB = 8'h02;
    localparam logic [FU_INSTR_W-1:0] OP_AND = 8'h04;
    localparam logic [FU_INSTR_W-1:0] OP_OR  = 8'h08;
    localparam logic [FU_INSTR_W-1:0] OP_MAX = 8'h10;
    localparam logic [FU_INSTR_W-1:0] OP_MIN = 8'h20;
    localparam logic [FU_INSTR_W-1:0] OP_XOR = 8'h40;
    localparam logic [FU_INSTR_W-1:0] OP_SHL = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } sched_state_t;

endpackage

// File: rtl/fu_rr_scheduler_if.sv
// Request/response channel between client blocks (master) and the FU scheduler (slave).
interface fu_rr_scheduler_if
    import fu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int IDW     = 2
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*FU_INSTR_W-1:0] req_instr;
    logic [NUM_REQ*DW-1:0]         req_a;
    logic [NUM_REQ*DW-1:0]         req_b;
    logic [NUM_REQ*DW-1:0]         req_c;
    logic [NUM_REQ*FU_SEL_W-1:0]   req_sel;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DW-1:0]                 rsp_data;
    logic [IDW-1:0]                rsp_id;

    modport master (
        output req_valid, req_instr, req_a, req_b, req_c, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_instr, req_a, req_b, req_c, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/fu_rr_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr (with wrap) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/fu_rr_scheduler.sv
// Time-shares one combinational FU among NUM_REQ requesters with round-robin grants;
// one transaction outstanding, result returned tagged with the requester id.
module fu_rr_scheduler
    import fu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fu_rr_scheduler_if.slave      bus,
    output logic [FU_INSTR_W-1:0] fu_instr,
    output logic [DW-1:0]         fu_a,
    output logic [DW-1:0]         fu_b,
    output logic [DW-1:0]         fu_c,
    output logic [FU_SEL_W-1:0]   fu_sel,
    input  logic [DW-1:0]         fu_f,
    output logic [15:0]           op_count
);

    sched_state_t       state;
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     win_idx;
    logic               win_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The accept strobe must be combinational so the grant lands in the same cycle.
    assign bus.req_ready = (rst_n && state == ST_IDLE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            fu_instr      <= '0;
            fu_a          <= '0;
            fu_b          <= '0;
            fu_c          <= '0;
            fu_sel        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            op_count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        fu_instr   <= bus.req_instr[win_idx*FU_INSTR_W +: FU_INSTR_W];
                        fu_a       <= bus.req_a[win_idx*DW +: DW];
                        fu_b       <= bus.req_b[win_idx*DW +: DW];
                        fu_c       <= bus.req_c[win_idx*DW +: DW];
                        fu_sel     <= bus.req_sel[win_idx*FU_SEL_W +: FU_SEL_W];
                        bus.rsp_id <= win_idx;
                        rr_ptr     <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    bus.rsp_data  <= fu_f;
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (op_count != '1)
                            op_count <= op_count + 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_rr_scheduler.sv
// Scoreboard bench for fu_rr_scheduler with a behavioural FU hooked to its FU ports.
module tb_fu_rr_scheduler;
    import fu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fu_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) bus ();

    logic [7:0]    fu_instr;
    logic [DW-1:0] fu_a, fu_b, fu_c, fu_f;
    logic [2:0]    fu_sel;
    logic [15:0]   op_count;

    fu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .fu_instr (fu_instr),
        .fu_a     (fu_a),
        .fu_b     (fu_b),
        .fu_c     (fu_c),
        .fu_sel   (fu_sel),
        .fu_f     (fu_f),
        .op_count (op_count)
    );

    function automatic logic [DW-1:0] fu_model(input logic [7:0] instr, input logic [2:0] sel,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
        logic [DW-1:0] x, y;
        case (sel)
            3'b011:  begin x = b; y = c; end
            3'b101:  begin x = a; y = c; end
            3'b110:  begin x = a; y = b; end
            default: begin x = c; y = a; end
        endcase
        if (instr[0])      return x + y;
        else if (instr[1]) return x - y;
        else if (instr[2]) return x & y;
        else if (instr[3]) return x | y;
        else if (instr[4]) return (x > y) ? x : y;
        else if (instr[5]) return (x < y) ? x : y;
        else if (instr[6]) return x ^ y;
        else if (instr[7]) return x << y[2:0];
        return '0;
    endfunction

    assign fu_f = fu_model(fu_instr, fu_sel, fu_a, fu_b, fu_c);

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_ids[$];
    int   grant_cycs[$];
    int   cyc = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic [IDW-1:0] prev_id   = '0;

    always @(negedge clk) begin
        exp_t e;
        int   g;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if ((bus.req_ready & bus.req_valid) != '0) begin
                g = 0;
                for (int j = 0; j < NUM_REQ; j++)
                    if (bus.req_ready[j]) g = j;
                check_eq("grant_onehot", $countones(bus.req_ready), 1);
                e.id   = IDW'(g);
                e.data = fu_model(bus.req_instr[g*8 +: 8], bus.req_sel[g*3 +: 3],
                                  bus.req_a[g*DW +: DW], bus.req_b[g*DW +: DW],
                                  bus.req_c[g*DW +: DW]);
                e.cyc  = cyc;
                sb.push_back(e);
                grant_ids.push_back(g);
                grant_cycs.push_back(cyc);
            end
            if (bus.rsp_valid && !prev_valid) begin
                if (sb.size() == 0) check_eq("rsp_unexpected", sb.size(), 1);
                else                check_eq("rsp_latency", cyc - sb[0].cyc, 2);
            end
            if (bus.rsp_valid && prev_valid && !prev_ready) begin
                check_eq("hold_data", bus.rsp_data, prev_data);
                check_eq("hold_id", bus.rsp_id, prev_id);
            end
            if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_id", bus.rsp_id, e.id);
                check_eq("sb_data", bus.rsp_data, e.data);
            end
            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_data  = bus.rsp_data;
            prev_id    = bus.rsp_id;
        end
    end

    task automatic set_req(input int i, input logic [7:0] instr, input logic [2:0] sel,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req_instr[i*8 +: 8]  = instr;
        bus.req_sel[i*3 +: 3]    = sel;
        bus.req_a[i*DW +: DW]    = a;
        bus.req_b[i*DW +: DW]    = b;
        bus.req_c[i*DW +: DW]    = c;
        bus.req_valid[i]         = 1'b1;
    endtask

    task automatic wait_grant();
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((bus.req_ready & bus.req_valid) != '0) got = 1'b1;
        end
        check_eq("grant_seen", got, 1);
    endtask

    task automatic wait_rsp();
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check_eq("rsp_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (!bus.rsp_valid && sb.size() == 0 && bus.req_valid == '0) got = 1'b1;
        end
        check_eq("idle_seen", got, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic single_op(input int i, input logic [7:0] instr, input logic [2:0] sel,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(posedge clk); #1;
        set_req(i, instr, sel, a, b, c);
        wait_grant();
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();
    endtask

    initial begin
        logic [15:0] cnt0;
        bus.req_valid = '1;
        bus.req_instr = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;

        // reset state, with every requester asking
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_valid", bus.rsp_valid, 0);
        check_eq("rst_data", bus.rsp_data, 0);
        check_eq("rst_id", bus.rsp_id, 0);
        check_eq("rst_count", op_count, 0);
        check_eq("rst_fu", {fu_instr, fu_a, fu_b, fu_c, fu_sel}, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;

        // single req0 add
        @(posedge clk); #1;
        set_req(0, OP_ADD, SEL_AB, 8'd3, 8'd5, 8'd0);
        wait_grant();
        check_eq("t1_ready", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp();
        check_eq("t1_data", bus.rsp_data, 8);
        check_eq("t1_id", bus.rsp_id, 0);
        wait_idle();
        check_eq("t1_count", op_count, 1);
        check_eq("t1_fu_keep", fu_a, 3);

        // all four held high
        do_reset();
        grant_ids.delete();
        grant_cycs.delete();
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 8'h01 << i, (i == 1) ? SEL_BC : SEL_AB, 8'(17 * i + 3), 8'(29 + i), 8'(100 - i));
        for (int k = 0; k < 40 && grant_ids.size() < 5; k++) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        check_eq("t2_ngrants", grant_ids.size(), 5);
        if (grant_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_eq("t2_order", grant_ids[k], k % NUM_REQ);
            for (int k = 1; k < 5; k++) check_eq("t2_interval", grant_cycs[k] - grant_cycs[k-1], 3);
        end
        wait_idle();
        check_eq("t2_count", op_count, 5);

        // backpressured response held stable
        cnt0 = op_count;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(2, OP_MAX, SEL_AC, 8'd200, 8'd7, 8'd90);
        wait_grant();
        check_eq("t3_ready", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_valid", bus.rsp_valid, 1);
            check_eq("t3_data", bus.rsp_data, 200);
            check_eq("t3_id", bus.rsp_id, 2);
            check_eq("t3_count_hold", op_count, cnt0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle();
        check_eq("t3_count", op_count, cnt0 + 16'd1);

        // reset while the FU is executing
        @(posedge clk); #1;
        set_req(1, OP_SUB, SEL_AB, 8'd9, 8'd4, 8'd0);
        wait_grant();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t4_valid", bus.rsp_valid, 0);
        check_eq("t4_fu", {fu_instr, fu_a, fu_b, fu_c, fu_sel}, 0);
        check_eq("t4_rsp", {bus.rsp_data, bus.rsp_id}, 0);
        check_eq("t4_count", op_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t4_no_rsp", bus.rsp_valid, 0);
        end

        // only req3 with rr_ptr at 0, then pointer wraps to 0
        @(posedge clk); #1;
        set_req(3, OP_XOR, SEL_BC, 8'd0, 8'h5A, 8'h0F);
        wait_grant();
        check_eq("t5_ready", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();
        @(posedge clk); #1;
        set_req(0, OP_OR, SEL_AB, 8'h30, 8'h03, 8'd0);
        set_req(3, OP_MIN, SEL_AB, 8'd50, 8'd40, 8'd0);
        wait_grant();
        check_eq("t5_wrap", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // mixed traffic checked by the scoreboard
        for (int n = 0; n < 10; n++)
            single_op($urandom_range(0, NUM_REQ - 1), 8'($urandom), 3'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom));

        // counter saturation
        @(posedge clk); #1;
        force dut.op_count = 16'hFFFE;
        #1 release dut.op_count;
        single_op(1, OP_ADD, SEL_AB, 8'd250, 8'd10, 8'd0);
        check_eq("t6_ffff", op_count, 16'hFFFF);
        single_op(2, OP_SHL, SEL_AB, 8'h81, 8'd1, 8'd0);
        check_eq("t6_sat", op_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
